// File: rtl/tlb_pkg.sv
// Shared types and helpers for the fully associative TLB.
// Optional feature macro: TLB_ASID_EN (ASID-tagged entries with a global bit).
package tlb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_WALK   = 2'd2
  } tlb_state_e;

  localparam int unsigned FAULT_CAUSE_W = 2;

  typedef logic [FAULT_CAUSE_W-1:0] fault_cause_t;

  localparam fault_cause_t FAULT_NONE = 2'd0;
  localparam fault_cause_t FAULT_WALK = 2'd1;
  localparam fault_cause_t FAULT_PERM = 2'd2;

  // Page-number width left after removing the untranslated page offset.
  function automatic int unsigned page_num_width(input int unsigned addr_w,
                                                 input int unsigned offset_w);
    return addr_w - offset_w;
  endfunction

endpackage

// File: rtl/tlb_victim_select.sv
// Replacement victim: lowest-index invalid entry, else a round-robin pointer.
module tlb_victim_select #(
  parameter int unsigned N_LINES = 8,
  parameter int unsigned IDX_W   = $clog2(N_LINES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_LINES-1:0] valid,
  input  logic               advance,
  input  logic               clear,
  output logic [IDX_W-1:0]   victim_c
);

  logic             free_c;
  logic [IDX_W-1:0] free_idx_c;
  logic [IDX_W-1:0] ptr_q;

  // Priority-encode the lowest invalid entry.
  always_comb begin
    free_c     = 1'b0;
    free_idx_c = '0;
    for (int i = 0; i < N_LINES; i++) begin
      if (!valid[i] && !free_c) begin
        free_c     = 1'b1;
        free_idx_c = IDX_W'(i);
      end
    end
  end

  assign victim_c = free_c ? free_idx_c : ptr_q;

  // Pointer moves only when it actually chose the victim; wraps since N_LINES is a power of two.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      ptr_q <= '0;
    end else if (advance && !free_c) begin
      ptr_q <= ptr_q + IDX_W'(1);
    end
  end

endmodule

// File: rtl/tlb_walk_assoc.sv
// Fully associative TLB with write-permission check, flushes and walker refill.
// Optional feature macro: TLB_ASID_EN (per-entry ASID and global bit).
module tlb_walk_assoc
  import tlb_pkg::*;
#(
  parameter int unsigned N_LINES     = 8,
  parameter int unsigned VA_WIDTH    = 32,
  parameter int unsigned PA_WIDTH    = 32,
  parameter int unsigned PAGE_OFFSET = 12,
  parameter int unsigned ASID_WIDTH  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_req_valid,
  output logic                            o_req_ready,
  input  logic [VA_WIDTH-1:0]             i_req_vaddr,
  input  logic                            i_req_write,
  input  logic [ASID_WIDTH-1:0]           i_req_asid,
  output logic                            o_resp_valid,
  output logic [PA_WIDTH-1:0]             o_resp_paddr,
  output logic                            o_resp_fault,
  output logic                            o_walk_req_valid,
  output logic [VA_WIDTH-PAGE_OFFSET-1:0] o_walk_req_vpn,
  input  logic                            i_walk_resp_valid,
  input  logic [PA_WIDTH-PAGE_OFFSET-1:0] i_walk_resp_ppn,
  input  logic                            i_walk_resp_writable,
  input  logic                            i_walk_resp_global,
  input  logic                            i_walk_resp_error,
  input  logic                            i_flush_all,
  input  logic                            i_flush_vpn_valid,
  input  logic [VA_WIDTH-PAGE_OFFSET-1:0] i_flush_vpn
);

  localparam int unsigned VPN_W = page_num_width(VA_WIDTH, PAGE_OFFSET);
  localparam int unsigned PPN_W = page_num_width(PA_WIDTH, PAGE_OFFSET);
  localparam int unsigned IDX_W = $clog2(N_LINES);

  tlb_state_e             state_q;
  logic [VPN_W-1:0]       req_vpn;
  logic [PAGE_OFFSET-1:0] req_off;
  logic                   req_write;

  logic [N_LINES-1:0]     ent_valid;
  logic [VPN_W-1:0]       ent_vpn      [N_LINES];
  logic [PPN_W-1:0]       ent_ppn      [N_LINES];
  logic                   ent_writable [N_LINES];

`ifdef TLB_ASID_EN
  logic [ASID_WIDTH-1:0]  req_asid;
  logic [ASID_WIDTH-1:0]  ent_asid     [N_LINES];
  logic                   ent_global   [N_LINES];
`else
  logic                   unused_asid_c;
  assign unused_asid_c = ^{i_req_asid, i_walk_resp_global};
`endif

  logic [N_LINES-1:0]     match_c;
  logic                   hit_c;
  logic [IDX_W-1:0]       hit_idx_c;
  fault_cause_t           hit_cause_c;
  fault_cause_t           walk_cause_c;
  logic                   install_c;
  logic [IDX_W-1:0]       victim_c;

  // Per-entry tag match against the registered request.
  always_comb begin
    match_c = '0;
    for (int i = 0; i < N_LINES; i++) begin
`ifdef TLB_ASID_EN
      match_c[i] = ent_valid[i] && (ent_vpn[i] == req_vpn) &&
                   (ent_global[i] || (ent_asid[i] == req_asid));
`else
      match_c[i] = ent_valid[i] && (ent_vpn[i] == req_vpn);
`endif
    end
  end

  // Lowest matching index wins should duplicates ever exist.
  always_comb begin
    hit_c     = 1'b0;
    hit_idx_c = '0;
    for (int i = 0; i < N_LINES; i++) begin
      if (match_c[i] && !hit_c) begin
        hit_c     = 1'b1;
        hit_idx_c = IDX_W'(i);
      end
    end
  end

  // Fault causes for a hit and for a walker reply.
  always_comb begin
    hit_cause_c  = FAULT_NONE;
    walk_cause_c = FAULT_NONE;
    if (req_write && !ent_writable[hit_idx_c]) begin
      hit_cause_c = FAULT_PERM;
    end
    if (i_walk_resp_error) begin
      walk_cause_c = FAULT_WALK;
    end else if (req_write && !i_walk_resp_writable) begin
      walk_cause_c = FAULT_PERM;
    end
  end

  // A coincident flush covering the new entry cancels the install.
  assign install_c = (state_q == ST_WALK) && i_walk_resp_valid && !i_walk_resp_error &&
                     !i_flush_all && !(i_flush_vpn_valid && (i_flush_vpn == req_vpn));

  tlb_victim_select #(
    .N_LINES (N_LINES),
    .IDX_W   (IDX_W)
  ) u_victim (
    .clk      (clk),
    .rst      (rst),
    .valid    (ent_valid),
    .advance  (install_c),
    .clear    (i_flush_all),
    .victim_c (victim_c)
  );

  // Request/walk FSM with registered handshake and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      o_req_ready      <= 1'b0;
      o_resp_valid     <= 1'b0;
      o_resp_paddr     <= '0;
      o_resp_fault     <= 1'b0;
      o_walk_req_valid <= 1'b0;
      o_walk_req_vpn   <= '0;
      req_vpn          <= '0;
      req_off          <= '0;
      req_write        <= 1'b0;
`ifdef TLB_ASID_EN
      req_asid         <= '0;
`endif
    end else begin
      o_resp_valid <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          o_req_ready <= 1'b1;
          if (i_req_valid && o_req_ready) begin
            req_vpn     <= i_req_vaddr[VA_WIDTH-1:PAGE_OFFSET];
            req_off     <= i_req_vaddr[PAGE_OFFSET-1:0];
            req_write   <= i_req_write;
`ifdef TLB_ASID_EN
            req_asid    <= i_req_asid;
`endif
            o_req_ready <= 1'b0;
            state_q     <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (hit_c) begin
            o_resp_valid <= 1'b1;
            o_resp_paddr <= {ent_ppn[hit_idx_c], req_off};
            o_resp_fault <= (hit_cause_c != FAULT_NONE);
            o_req_ready  <= 1'b1;
            state_q      <= ST_IDLE;
          end else begin
            o_walk_req_valid <= 1'b1;
            o_walk_req_vpn   <= req_vpn;
            state_q          <= ST_WALK;
          end
        end
        ST_WALK: begin
          if (i_walk_resp_valid) begin
            o_walk_req_valid <= 1'b0;
            o_resp_valid     <= 1'b1;
            o_resp_paddr     <= i_walk_resp_error ? '0 : {i_walk_resp_ppn, req_off};
            o_resp_fault     <= (walk_cause_c != FAULT_NONE);
            o_req_ready      <= 1'b1;
            state_q          <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Valid bits: flushes clear, a surviving install sets the victim.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent_valid <= '0;
    end else begin
      for (int i = 0; i < N_LINES; i++) begin
        if (i_flush_all || (i_flush_vpn_valid && (ent_vpn[i] == i_flush_vpn))) begin
          ent_valid[i] <= 1'b0;
        end
      end
      if (install_c) begin
        ent_valid[victim_c] <= 1'b1;
      end
    end
  end

  // Entry payload, written only on install.
  always_ff @(posedge clk) begin
    if (install_c) begin
      ent_vpn[victim_c]      <= req_vpn;
      ent_ppn[victim_c]      <= i_walk_resp_ppn;
      ent_writable[victim_c] <= i_walk_resp_writable;
`ifdef TLB_ASID_EN
      ent_asid[victim_c]     <= req_asid;
      ent_global[victim_c]   <= i_walk_resp_global;
`endif
    end
  end

endmodule

// File: tb/tb_tlb_walk_assoc.sv
// Directed bench for tlb_walk_assoc (N_LINES=4, 32-bit VA/PA, 4 KiB pages).
module tb_tlb_walk_assoc;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [31:0] i_req_vaddr;
  logic        i_req_write;
  logic [3:0]  i_req_asid;
  logic        o_resp_valid;
  logic [31:0] o_resp_paddr;
  logic        o_resp_fault;
  logic        o_walk_req_valid;
  logic [19:0] o_walk_req_vpn;
  logic        i_walk_resp_valid;
  logic [19:0] i_walk_resp_ppn;
  logic        i_walk_resp_writable;
  logic        i_walk_resp_global;
  logic        i_walk_resp_error;
  logic        i_flush_all;
  logic        i_flush_vpn_valid;
  logic [19:0] i_flush_vpn;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  tlb_walk_assoc #(
    .N_LINES     (4),
    .VA_WIDTH    (32),
    .PA_WIDTH    (32),
    .PAGE_OFFSET (12),
    .ASID_WIDTH  (4)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .i_req_valid          (i_req_valid),
    .o_req_ready          (o_req_ready),
    .i_req_vaddr          (i_req_vaddr),
    .i_req_write          (i_req_write),
    .i_req_asid           (i_req_asid),
    .o_resp_valid         (o_resp_valid),
    .o_resp_paddr         (o_resp_paddr),
    .o_resp_fault         (o_resp_fault),
    .o_walk_req_valid     (o_walk_req_valid),
    .o_walk_req_vpn       (o_walk_req_vpn),
    .i_walk_resp_valid    (i_walk_resp_valid),
    .i_walk_resp_ppn      (i_walk_resp_ppn),
    .i_walk_resp_writable (i_walk_resp_writable),
    .i_walk_resp_global   (i_walk_resp_global),
    .i_walk_resp_error    (i_walk_resp_error),
    .i_flush_all          (i_flush_all),
    .i_flush_vpn_valid    (i_flush_vpn_valid),
    .i_flush_vpn          (i_flush_vpn)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One request from a negedge; optionally answers the walk (with an optional coincident flush_all).
  task automatic xact(input logic [31:0] va, input logic wr, input logic [3:0] asid,
                      input logic walk, input logic [19:0] ppn, input logic wbl,
                      input logic glb, input logic err, input logic fl,
                      input logic [31:0] exp_pa, input logic exp_f);
    int unsigned waited = 0;
    logic [19:0] vpn;
    vpn = va[31:12];
    while (!o_req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("req_ready", 64'(o_req_ready), 64'd1);
    i_req_valid = 1'b1;
    i_req_vaddr = va;
    i_req_write = wr;
    i_req_asid  = asid;
    @(negedge clk);
    i_req_valid = 1'b0;
    check("busy_after_accept", 64'(o_req_ready), 64'd0);
    @(negedge clk);
    if (!walk) begin
      check("hit_resp_valid", 64'(o_resp_valid), 64'd1);
      check("hit_no_walk", 64'(o_walk_req_valid), 64'd0);
    end else begin
      check("miss_resp_quiet", 64'(o_resp_valid), 64'd0);
      check("walk_valid", 64'(o_walk_req_valid), 64'd1);
      check("walk_vpn", 64'(o_walk_req_vpn), 64'(vpn));
      @(negedge clk);
      check("walk_held", 64'({o_walk_req_valid, o_walk_req_vpn}), 64'({1'b1, vpn}));
      i_walk_resp_valid    = 1'b1;
      i_walk_resp_ppn      = ppn;
      i_walk_resp_writable = wbl;
      i_walk_resp_global   = glb;
      i_walk_resp_error    = err;
      i_flush_all          = fl;
      @(negedge clk);
      i_walk_resp_valid = 1'b0;
      i_walk_resp_error = 1'b0;
      i_flush_all       = 1'b0;
      check("walk_dropped", 64'(o_walk_req_valid), 64'd0);
      check("walk_resp_valid", 64'(o_resp_valid), 64'd1);
    end
    check("resp_paddr", 64'(o_resp_paddr), 64'(exp_pa));
    check("resp_fault", 64'(o_resp_fault), 64'(exp_f));
    check("ready_with_resp", 64'(o_req_ready), 64'd1);
    @(negedge clk);
    check("resp_pulse", 64'(o_resp_valid), 64'd0);
  endtask

  task automatic flush_vpn(input logic [19:0] vpn);
    i_flush_vpn_valid = 1'b1;
    i_flush_vpn       = vpn;
    @(negedge clk);
    i_flush_vpn_valid = 1'b0;
  endtask

  task automatic flush_all_now();
    i_flush_all = 1'b1;
    @(negedge clk);
    i_flush_all = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    i_req_valid = 1'b0; i_req_vaddr = '0; i_req_write = 1'b0; i_req_asid = '0;
    i_walk_resp_valid = 1'b0; i_walk_resp_ppn = '0; i_walk_resp_writable = 1'b0;
    i_walk_resp_global = 1'b0; i_walk_resp_error = 1'b0;
    i_flush_all = 1'b0; i_flush_vpn_valid = 1'b0; i_flush_vpn = '0;

    // Reset state and ready rising one cycle after release.
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(o_req_ready), 64'd0);
    check("rst_resp_valid", 64'(o_resp_valid), 64'd0);
    check("rst_walk_valid", 64'(o_walk_req_valid), 64'd0);
    check("rst_paddr", 64'(o_resp_paddr), 64'd0);
    rst = 1'b0;
    check("ready_low_at_release", 64'(o_req_ready), 64'd0);
    @(negedge clk);
    check("ready_after_release", 64'(o_req_ready), 64'd1);

    // Basic miss, refill, and hit.
    xact(32'h0001_2345, 1'b0, 4'd0, 1'b1, 20'h00ABC, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00AB_C345, 1'b0);
    xact(32'h0001_2345, 1'b0, 4'd0, 1'b0, 20'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00AB_C345, 1'b0);
    xact(32'h0001_2FFF, 1'b1, 4'd0, 1'b0, 20'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00AB_CFFF, 1'b0);

    // Read-only page: writes fault with paddr intact, reads do not.
    xact(32'h0002_0010, 1'b1, 4'd0, 1'b1, 20'h00555, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0055_5010, 1'b1);
    xact(32'h0002_0010, 1'b1, 4'd0, 1'b0, 20'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0055_5010, 1'b1);
    xact(32'h0002_0010, 1'b0, 4'd0, 1'b0, 20'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0055_5010, 1'b0);

    // Walk error: fault, paddr 0, nothing installed so the retry walks again.
    xact(32'h0007_7ABC, 1'b0, 4'd0, 1'b1, 20'h00999, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b1);
    xact(32'h0007_7ABC, 1'b0, 4'd0, 1'b1, 20'h00777, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0077_7ABC, 1'b0);

    // Reset in the middle of a walk; the late walk response must be ignored.
    i_req_valid = 1'b1; i_req_vaddr = 32'h0009_9000; i_req_write = 1'b0;
    @(negedge clk);
    i_req_valid = 1'b0;
    @(negedge clk);
    check("midwalk_walk_valid", 64'(o_walk_req_valid), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_aborts_walk", 64'(o_walk_req_valid), 64'd0);
    check("rst_ready_low", 64'(o_req_ready), 64'd0);
    rst = 1'b0;
    i_walk_resp_valid = 1'b1; i_walk_resp_ppn = 20'h00DEF; i_walk_resp_writable = 1'b1;
    @(negedge clk);
    i_walk_resp_valid = 1'b0;
    check("late_walk_resp_ignored", 64'(o_resp_valid), 64'd0);
    check("ready_after_midwalk_rst", 64'(o_req_ready), 64'd1);
    xact(32'h0001_2345, 1'b0, 4'd0, 1'b1, 20'h00ABC, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00AB_C345, 1'b0);

    // Fill vpn 1..4, then vpn 5 evicts line 0 (vpn 1) via the RR pointer.
    pulse_reset();
    for (int k = 1; k <= 5; k++) begin
      xact({20'(k), 12'h0AB}, 1'b0, 4'd0, 1'b1, 20'h00100 + 20'(k), 1'b1, 1'b0, 1'b0, 1'b0,
           {20'h00100 + 20'(k), 12'h0AB}, 1'b0);
    end
    for (int k = 2; k <= 4; k++) begin
      xact({20'(k), 12'h0AB}, 1'b0, 4'd0, 1'b0, 20'h0, 1'b0, 1'b0, 1'b0, 1'b0,
           {20'h00100 + 20'(k), 12'h0AB}, 1'b0);
    end
    xact(32'h0000_10AB, 1'b0, 4'd0, 1'b1, 20'h00201, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0020_10AB, 1'b0);
    xact(32'h0000_30AB, 1'b0, 4'd0, 1'b0, 20'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0010_30AB, 1'b0);

    // flush_vpn removes only the named page.
    flush_vpn(20'h00003);
    xact(32'h0000_40AB, 1'b0, 4'd0, 1'b0, 20'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0010_40AB, 1'b0);
    xact(32'h0000_30AB, 1'b0, 4'd0, 1'b1, 20'h00303, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0030_30AB, 1'b0);

    // flush_all empties the table.
    flush_all_now();
    xact(32'h0000_40AB, 1'b0, 4'd0, 1'b1, 20'h00404, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0040_40AB, 1'b0);
    xact(32'h0000_10AB, 1'b0, 4'd0, 1'b1, 20'h00501, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0050_10AB, 1'b0);

    // Flush coincident with the walk reply: response delivered, nothing installed.
    xact(32'h0003_0123, 1'b0, 4'd0, 1'b1, 20'h00333, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0033_3123, 1'b0);
    xact(32'h0003_0123, 1'b0, 4'd0, 1'b1, 20'h00334, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0033_4123, 1'b0);

`ifdef TLB_ASID_EN
    // ASID tagging: private entry misses for another ASID, global entry hits.
    xact(32'h0004_0010, 1'b0, 4'd3, 1'b1, 20'h00A40, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00A4_0010, 1'b0);
    xact(32'h0004_0010, 1'b0, 4'd5, 1'b1, 20'h00B40, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00B4_0010, 1'b0);
    xact(32'h0004_0010, 1'b0, 4'd3, 1'b0, 20'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00A4_0010, 1'b0);
    xact(32'h0004_1010, 1'b0, 4'd3, 1'b1, 20'h00A41, 1'b1, 1'b1, 1'b0, 1'b0, 32'h00A4_1010, 1'b0);
    xact(32'h0004_1010, 1'b0, 4'd5, 1'b0, 20'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00A4_1010, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tlb_walk_assoc.md
Name: tlb_walk_assoc

Overview:
Fully associative, parametrised TLB with page-granular translation, write-permission checking, flush-all and flush-by-VPN, and a miss-refill handshake to an external page-table walker. It sits between the load/store unit and the walker. It keeps one request outstanding and returns a one-cycle response pulse per accepted request.

Parameters:
N_LINES, 8, entries; power of two, >=2
VA_WIDTH, 32, virtual address width
PA_WIDTH, 32, physical address width
PAGE_OFFSET, 12, untranslated offset bits; VPN_W=VA_WIDTH-PAGE_OFFSET, PPN_W=PA_WIDTH-PAGE_OFFSET
ASID_WIDTH, 4, address-space id width (used only with TLB_ASID_EN)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_req_valid  in  1  translation request
o_req_ready  out  1  TLB idle, request accepted when valid&ready
i_req_vaddr  in  VA_WIDTH  virtual address
i_req_write  in  1  request is a store
i_req_asid  in  ASID_WIDTH  requester ASID
o_resp_valid  out  1  one-cycle response pulse
o_resp_paddr  out  PA_WIDTH  {ppn, offset}
o_resp_fault  out  1  walk error or write to read-only page
o_walk_req_valid  out  1  walk request, held until response
o_walk_req_vpn  out  VPN_W  VPN to walk
i_walk_resp_valid  in  1  walker done
i_walk_resp_ppn  in  PPN_W  translated PPN
i_walk_resp_writable  in  1  page writable
i_walk_resp_global  in  1  page global (ASID-ignored)
i_walk_resp_error  in  1  no mapping
i_flush_all  in  1  invalidate all entries
i_flush_vpn_valid  in  1  invalidate entries matching i_flush_vpn
i_flush_vpn  in  VPN_W  VPN to invalidate

Behaviour:
- Reset (synchronous): state IDLE, all valid bits 0, RR pointer 0, all outputs 0. o_req_ready rises the cycle after rst deasserts. Reset mid-walk aborts the walk. o_walk_req_valid is 0 the next cycle, and any later walk response is ignored.
- FSM IDLE -> LOOKUP on accept. The request is registered and ready=0.
- LOOKUP compares the registered VPN against all valid entries.
  - Hit: response registered, state -> IDLE. o_resp_valid is high the cycle after LOOKUP, i.e. 2 cycles after accept. Ready is 1 in that same cycle.
  - Miss: state -> WALK.
- WALK: o_walk_req_valid=1 and o_walk_req_vpn stable until i_walk_resp_valid. On response, state -> IDLE and o_resp_valid pulses the next cycle.
  - error=1: fault=1, paddr=0, no install.
  - Otherwise: install into the victim entry, then respond.
  - i_walk_resp_valid outside WALK is ignored.
- Fault rule: fault = error | (write & !writable). paddr is still {ppn, offset} on a permission fault.
- Multiple hits cannot arise, because installs happen only on a miss. If they do, the lowest index wins.
- Victim selection: lowest-index invalid entry; if none, the RR pointer. The pointer advances (mod N_LINES) only when it was used.
- Flush effects take place at the clock edge. A lookup in the same cycle sees pre-flush contents. flush_vpn clears all matching entries regardless of ASID. flush_all also resets the RR pointer to 0.
- Flush in the same cycle as an install: the flush wins and the entry is not installed, but the response is still delivered.
- The response has no backpressure; the consumer must take the pulse.

Optional Feature:
TLB_ASID_EN
- Defined: each entry stores ASID and global bit. Hit requires VPN match and (global | asid match). The install captures i_req_asid and i_walk_resp_global.
- Undefined: no ASID/global storage, and i_req_asid and i_walk_resp_global are ignored. Ports are present in both builds.

Decomposition:
- Package tlb_pkg: state enum (IDLE, LOOKUP, WALK), fault-cause constants, a helper function computing VPN_W/PPN_W.
- Sub-module tlb_victim_select: invalid-priority encoder plus RR pointer. Inputs: valid vector, advance. Output: victim index.

Test Plan (N_LINES=4, 32/32/12):
1. Read 0x0001_2345 -> walk vpn 0x00012; reply ppn 0x00ABC, writable -> paddr 0x00AB_C345, fault 0. Repeat -> resp 2 cycles after accept, no walk.
2. Install vpn 0x00020 read-only. Write 0x0002_0010 -> fault 1, paddr 0x<ppn>010. Read of the same address -> fault 0.
3. Fill vpn 1..4, then request vpn 5 -> evicts line 0 (vpn 1). Request vpn 1 -> walk; vpn 3 -> hit.
4. flush_vpn 0x00002 -> vpn 2 misses, vpn 3 hits. flush_all -> all miss. Flush coincident with walk response -> response delivered, and the next identical request walks again.
5. Walk error for vpn 0x00077 -> fault 1, no install. Retry -> walk issued again.
6. rst asserted during WALK -> walk_req_valid 0 next cycle, ready 1 after release, prior entries miss. With TLB_ASID_EN, ASID 3 entry misses for ASID 5 unless global.
